// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS multicycle control slice:
// state and class encodings, opcode values, ALU/PC selects and the strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } ctrlState_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    CL_RTYPE = 4'd0,
    CL_LW    = 4'd1,
    CL_SW    = 4'd2,
    CL_BEQ   = 4'd3,
    CL_BNE   = 4'd4,
    CL_J     = 4'd5,
    CL_ADDI  = 4'd6,
    CL_ANDI  = 4'd7,
    CL_ORI   = 4'd8
  } opClass_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrc;
    logic       memRead;
    logic       memWrite;
    logic       unsign;
    logic [2:0] aluCode;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(14'd0);

  // ALU operand/operation selects a class uses in EXEC; MEM and WB keep them held.
  function automatic ctrl_t execCtrl(input opClass_e cls);
    ctrl_t c;
    c = CTRL_IDLE;
    case (cls)
      CL_RTYPE: begin
        c.aluCode = ALU_FUNCT;
        c.aluSrc  = 1'b0;
      end
      CL_ADDI, CL_LW, CL_SW: begin
        c.aluCode = ALU_ADD;
        c.aluSrc  = 1'b1;
      end
      CL_ANDI: begin
        c.aluCode = ALU_AND;
        c.aluSrc  = 1'b1;
        c.unsign  = 1'b1;
      end
      CL_ORI: begin
        c.aluCode = ALU_OR;
        c.aluSrc  = 1'b1;
        c.unsign  = 1'b1;
      end
      CL_BEQ, CL_BNE: begin
        c.aluCode = ALU_SUB;
        c.aluSrc  = 1'b0;
      end
      default: begin
        c = CTRL_IDLE;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Control/datapath bundle between the multicycle sequencer (master) and the
// MIPS datapath (slave): IR opcode, ALU/RAM status in, strobes and selects out.
interface mips_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic       unsign;
  logic [2:0] alu_code;
  logic       illegal;
  ctrlState_e state;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           alu_src, mem_read, mem_write, unsign, alu_code, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           alu_src, mem_read, mem_write, unsign, alu_code, illegal, state
  );

endinterface

// File: rtl/mips_opcode_decode.sv
// Combinational opcode-to-class mapping; anything outside the supported set
// is flagged as not legal and reported as RTYPE.
module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output opClass_e   opClass,
  output logic       legal
);

  // Opcode lookup
  always_comb begin
    opClass = CL_RTYPE;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: opClass = CL_RTYPE;
      OP_LW:    opClass = CL_LW;
      OP_SW:    opClass = CL_SW;
      OP_BEQ:   opClass = CL_BEQ;
      OP_BNE:   opClass = CL_BNE;
      OP_J:     opClass = CL_J;
      OP_ADDI:  opClass = CL_ADDI;
      OP_ANDI:  opClass = CL_ANDI;
      OP_ORI:   opClass = CL_ORI;
      default: begin
        opClass = CL_RTYPE;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with RAM ready wait and
// sticky HALT on illegal opcodes. Define MIPS_CTRL_PERF_CNT_EN for cycle/instr counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef MIPS_CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  mips_ctrl_if.master bus
);

  ctrlState_e stateR;
  ctrlState_e nextStateS;
  opClass_e   classR;
  logic       illegalR;
  opClass_e   decClassS;
  logic       decLegalS;
  ctrl_t      ctrlDecS;
  ctrl_t      ctrlS;
  logic       takenS;

  mips_opcode_decode uDecode (
    .opcode  (bus.opcode),
    .opClass (decClassS),
    .legal   (decLegalS)
  );

  // State, latched class and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR   <= S_FETCH;
      classR   <= CL_RTYPE;
      illegalR <= 1'b0;
    end else begin
      stateR <= nextStateS;
      if (stateR == S_DECODE) begin
        classR <= decClassS;
      end
      if (nextStateS == S_HALT) begin
        illegalR <= 1'b1;
      end
    end
  end

  // Next state and per-state strobe decode
  always_comb begin
    nextStateS = stateR;
    ctrlDecS   = CTRL_IDLE;
    takenS     = 1'b0;
    case (stateR)
      S_FETCH: begin
        ctrlDecS.irWrite = 1'b1;
        nextStateS       = S_DECODE;
      end
      S_DECODE: begin
        if (decLegalS) begin
          nextStateS = S_EXEC;
        end else begin
          nextStateS = S_HALT;
        end
      end
      S_EXEC: begin
        ctrlDecS = execCtrl(classR);
        case (classR)
          CL_RTYPE, CL_ADDI, CL_ANDI, CL_ORI: nextStateS = S_WB;
          CL_LW, CL_SW:                       nextStateS = S_MEM;
          CL_BEQ, CL_BNE: begin
            if (classR == CL_BEQ) begin
              takenS = bus.zero;
            end else begin
              takenS = ~bus.zero;
            end
            ctrlDecS.pcWrite = 1'b1;
            ctrlDecS.pcSrc   = takenS ? PC_BRANCH : PC_PLUS4;
            nextStateS       = S_FETCH;
          end
          CL_J: begin
            ctrlDecS.pcWrite = 1'b1;
            ctrlDecS.pcSrc   = PC_JUMP;
            nextStateS       = S_FETCH;
          end
          default: nextStateS = S_HALT;
        endcase
      end
      S_MEM: begin
        ctrlDecS = execCtrl(classR);
        case (classR)
          CL_LW: begin
            ctrlDecS.memRead = 1'b1;
            if (bus.mem_ready) begin
              nextStateS = S_WB;
            end else begin
              nextStateS = S_MEM;
            end
          end
          CL_SW: begin
            // The store retires in the cycle RAM accepts it; no WB follows.
            ctrlDecS.memWrite = 1'b1;
            if (bus.mem_ready) begin
              ctrlDecS.pcWrite = 1'b1;
              ctrlDecS.pcSrc   = PC_PLUS4;
              nextStateS       = S_FETCH;
            end else begin
              nextStateS = S_MEM;
            end
          end
          default: nextStateS = S_HALT;
        endcase
      end
      S_WB: begin
        ctrlDecS          = execCtrl(classR);
        ctrlDecS.regWrite = 1'b1;
        ctrlDecS.pcWrite  = 1'b1;
        ctrlDecS.pcSrc    = PC_PLUS4;
        ctrlDecS.regDst   = (classR == CL_RTYPE);
        ctrlDecS.memToReg = (classR == CL_LW);
        nextStateS        = S_FETCH;
      end
      S_HALT: begin
        nextStateS = S_HALT;
      end
      default: begin
        nextStateS = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held, even mid-MEM
  always_comb begin
    if (!reset) begin
      ctrlS = CTRL_IDLE;
    end else begin
      ctrlS = ctrlDecS;
    end
  end

  assign bus.ir_write   = ctrlS.irWrite;
  assign bus.pc_write   = ctrlS.pcWrite;
  assign bus.pc_src     = ctrlS.pcSrc;
  assign bus.reg_write  = ctrlS.regWrite;
  assign bus.reg_dst    = ctrlS.regDst;
  assign bus.mem_to_reg = ctrlS.memToReg;
  assign bus.alu_src    = ctrlS.aluSrc;
  assign bus.mem_read   = ctrlS.memRead;
  assign bus.mem_write  = ctrlS.memWrite;
  assign bus.unsign     = ctrlS.unsign;
  assign bus.alu_code   = ctrlS.aluCode;
  assign bus.illegal    = illegalR;
  assign bus.state      = stateR;

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cycleCntR;
  logic [31:0] instrCntR;

  // Free-running performance counters, frozen cycle count while halted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCntR <= 32'd0;
      instrCntR <= 32'd0;
    end else begin
      if (stateR != S_HALT) begin
        cycleCntR <= cycleCntR + 32'd1;
      end
      if (ctrlS.pcWrite) begin
        instrCntR <= instrCntR + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycleCntR;
  assign instr_cnt = instrCntR;
`endif

endmodule
